// File: rtl/trng_entropy_collector.sv
// Ring-oscillator entropy collector: sync, sample, repetition test, 32-bit packing.
// Define TRNG_VN_DEBIAS_EN to insert von Neumann debiasing before the packer.
module trng_entropy_collector #(
  parameter int SAMPLE_DIV    = 4,
  parameter int WARMUP_CYCLES = 16,
  parameter int REP_LIMIT     = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        rosc_out,
  output logic        rosc_en,
  output logic [31:0] ehr_data,
  output logic        ehr_valid,
  input  logic        ehr_ready,
  output logic        health_fail,
  input  logic        clr_fail
);

  localparam int DW = $clog2(SAMPLE_DIV);
  localparam int WW = $clog2(WARMUP_CYCLES + 1);
  localparam int RW = $clog2(REP_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WARMUP,
    S_COLLECT,
    S_FULL,
    S_FAIL
  } state_t;

  state_t      r_state;
  logic        r_sync1;
  logic        r_sync2;
  logic [DW-1:0] r_div;
  logic [WW-1:0] r_warm;
  logic [RW-1:0] r_rep;
  logic        r_prev;
  logic [5:0]  r_bits;
  logic [31:0] r_data;
  logic        r_valid;
  logic        r_rosc_en;
  logic        r_fail;
`ifdef TRNG_VN_DEBIAS_EN
  logic        r_ph;
  logic        r_a;
`endif

  logic          w_tick;
  logic          w_smp;
  logic          w_same;
  logic [RW-1:0] w_rep_inc;
  logic [RW-1:0] w_rep_nxt;
  logic          w_hfail;
  logic          w_emit;
  logic          w_bit;
  logic          w_last;

  assign rosc_en     = r_rosc_en;
  assign ehr_data    = r_data;
  assign ehr_valid   = r_valid;
  assign health_fail = r_fail;

  // rosc_out is fully asynchronous; only r_sync2 is ever sampled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= rosc_out;
      r_sync2 <= r_sync1;
    end
  end

  assign w_tick = (r_state == S_COLLECT) &&
                  (r_div == DW'(SAMPLE_DIV - 1));
  assign w_smp  = r_sync2;

  // r_rep == 0 marks the first sample after COLLECT entry
  assign w_same    = (r_rep != '0) && (w_smp == r_prev);
  assign w_rep_inc = (r_rep == RW'(REP_LIMIT)) ?
                     r_rep : r_rep + RW'(1);
  assign w_rep_nxt = w_same ? w_rep_inc : RW'(1);
  assign w_hfail   = (w_rep_nxt == RW'(REP_LIMIT));

`ifdef TRNG_VN_DEBIAS_EN
  assign w_emit = r_ph && (r_a != w_smp);
  assign w_bit  = r_a;
`else
  assign w_emit = 1'b1;
  assign w_bit  = w_smp;
`endif

  assign w_last = (r_bits == 6'd31);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_warm    <= '0;
      r_rep     <= '0;
      r_prev    <= 1'b0;
      r_bits    <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_rosc_en <= 1'b0;
      r_fail    <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
      r_ph      <= 1'b0;
      r_a       <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (enable) begin
            r_state   <= S_WARMUP;
            r_warm    <= '0;
            r_rosc_en <= 1'b1;
          end
        end
        S_WARMUP: begin
          if (!enable) begin
            r_state   <= S_IDLE;
            r_rosc_en <= 1'b0;
          end else if (r_warm == WW'(WARMUP_CYCLES - 1)) begin
            r_state <= S_COLLECT;
            r_div   <= '0;
            r_rep   <= '0;
            r_bits  <= '0;
`ifdef TRNG_VN_DEBIAS_EN
            r_ph    <= 1'b0;
`endif
          end else begin
            r_warm <= r_warm + WW'(1);
          end
        end
        S_COLLECT: begin
          if (!enable) begin
            r_state   <= S_IDLE;
            r_rosc_en <= 1'b0;
          end else begin
            r_div <= w_tick ? '0 : r_div + DW'(1);
            if (w_tick) begin
              r_rep  <= w_rep_nxt;
              r_prev <= w_smp;
              // a failing sample is never packed, even as bit 32
              if (w_hfail) begin
                r_state   <= S_FAIL;
                r_fail    <= 1'b1;
                r_rosc_en <= 1'b0;
              end else begin
`ifdef TRNG_VN_DEBIAS_EN
                r_ph <= ~r_ph;
                if (!r_ph) r_a <= w_smp;
`endif
                if (w_emit) begin
                  r_data <= {r_data[30:0], w_bit};
                  r_bits <= r_bits + 6'd1;
                  if (w_last) begin
                    r_state   <= S_FULL;
                    r_valid   <= 1'b1;
                    r_rosc_en <= 1'b0;
                  end
                end
              end
            end
          end
        end
        S_FULL: begin
          if (r_valid && ehr_ready) begin
            r_valid <= 1'b0;
            if (enable) begin
              r_state   <= S_COLLECT;
              r_rosc_en <= 1'b1;
              r_div     <= '0;
              r_rep     <= '0;
              r_bits    <= '0;
`ifdef TRNG_VN_DEBIAS_EN
              r_ph      <= 1'b0;
`endif
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_FAIL: begin
          if (clr_fail) begin
            r_state <= S_IDLE;
            r_fail  <= 1'b0;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_valid   <= 1'b0;
          r_rosc_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trng_entropy_collector.sv
// Bench for trng_entropy_collector: directed raw-bit patterns, word scoreboard.
// Raw bits are driven in 4-cycle windows aligned to the collector's sample points.
module tb_trng_entropy_collector;

  localparam int P_ALT   = 0;
  localparam int P_STUCK = 1;
  localparam int P_CC    = 2;
  localparam int P_VN    = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        rosc_out = 1'b0;
  logic        ehr_ready = 1'b0;
  logic        clr_fail = 1'b0;
  logic        rosc_en;
  logic        ehr_valid;
  logic        health_fail;
  logic [31:0] ehr_data;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int t0 = 0;
  int pat = P_ALT;
  logic [31:0] exp_q[$];

  trng_entropy_collector #(
    .SAMPLE_DIV(4),
    .WARMUP_CYCLES(16),
    .REP_LIMIT(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .rosc_out(rosc_out),
    .rosc_en(rosc_en),
    .ehr_data(ehr_data),
    .ehr_valid(ehr_valid),
    .ehr_ready(ehr_ready),
    .health_fail(health_fail),
    .clr_fail(clr_fail)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Raw window j covers the values present at edges 17+4j..20+4j after
  // the edge that first sees enable; sample j is taken mid-window.
  initial begin
    int n;
    int j;
    int p;
    forever begin
      @(negedge clk);
      n = cyc - t0 + 1;
      if (pat == P_STUCK) begin
        rosc_out = 1'b1;
      end else if (n < 17) begin
        rosc_out = 1'b0;
      end else begin
        j = (n - 17) / 4;
        p = j >> 1;
        case (pat)
          P_ALT:   rosc_out = ~j[0];
          P_CC:    rosc_out = ~j[1];
          P_VN:    rosc_out = p[0] ? ~p[1] : j[0];
          default: rosc_out = 1'b0;
        endcase
      end
    end
  end

  initial begin
    logic        prev_v;
    logic        prev_hs;
    logic [31:0] prev_d;
    prev_v = 1'b0;
    prev_hs = 1'b0;
    prev_d = '0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_v = 1'b0;
      end else begin
        if (ehr_valid && prev_v && !prev_hs)
          chk("hold_data", ehr_data, prev_d);
        if (ehr_valid && ehr_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_word: got %h want none", ehr_data);
          end else begin
            chk("word", ehr_data, exp_q.pop_front());
          end
        end
        prev_v = ehr_valid;
        prev_d = ehr_data;
        prev_hs = ehr_valid && ehr_ready;
      end
    end
  end

  task automatic start(input int m);
    @(negedge clk);
    chk("rosc_en_pre", rosc_en, 1'b0);
    pat = m;
    enable = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    chk("rosc_en_rise", rosc_en, 1'b1);
  endtask

  task automatic wait_valid(input int exp_k, input string nm);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ehr_valid && k < 1000);
    if (!ehr_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no ehr_valid want valid", nm);
    end else begin
      chk(nm, cyc - t0, exp_k);
    end
  endtask

  task automatic stop_idle(input string nm);
    enable = 1'b0;
    repeat (5) @(negedge clk);
    chk({nm, "_rosc_off"}, rosc_en, 1'b0);
    chk({nm, "_valid_off"}, ehr_valid, 1'b0);
  endtask

  initial begin
    int k;
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_rosc_en", rosc_en, 1'b0);
    chk("rst_valid", ehr_valid, 1'b0);
    chk("rst_fail", health_fail, 1'b0);
    chk("rst_data", ehr_data, 32'h0);
    rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_rosc_en", rosc_en, 1'b0);
      chk("idle_valid", ehr_valid, 1'b0);
    end

`ifdef TRNG_VN_DEBIAS_EN
    ehr_ready = 1'b1;
    start(P_VN);
    exp_q.push_back(32'h0000_0000);
    wait_valid(520, "vn_latency");
    stop_idle("vn");
`else
    // two back-to-back words with ready held high
    ehr_ready = 1'b1;
    start(P_ALT);
    exp_q.push_back(32'hAAAA_AAAA);
    exp_q.push_back(32'hAAAA_AAAA);
    wait_valid(144, "w1_latency");
    wait_valid(273, "w2_latency");
    stop_idle("t2");

    // backpressure: word held, oscillator off, no rewarm after transfer
    ehr_ready = 1'b0;
    start(P_ALT);
    exp_q.push_back(32'hAAAA_AAAA);
    wait_valid(144, "bp_latency");
    repeat (51) begin
      @(negedge clk);
      chk("bp_valid_hold", ehr_valid, 1'b1);
      chk("bp_rosc_off", rosc_en, 1'b0);
    end
    ehr_ready = 1'b1;
    @(negedge clk);
    ehr_ready = 1'b0;
    chk("bp_valid_drop", ehr_valid, 1'b0);
    chk("bp_rosc_back", rosc_en, 1'b1);
    exp_q.push_back(32'h5555_5555);
    ehr_ready = 1'b1;
    wait_valid(324, "bp_nowarm");
    stop_idle("t3");

    // stuck source trips the repetition test on sample 32
    start(P_STUCK);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!health_fail && k < 1000);
    chk("fail_latency", cyc - t0, 144);
    chk("fail_rosc_off", rosc_en, 1'b0);
    chk("fail_no_valid", ehr_valid, 1'b0);
    repeat (5) @(negedge clk);
    chk("fail_sticky", health_fail, 1'b1);
    clr_fail = 1'b1;
    pat = P_ALT;
    @(negedge clk);
    clr_fail = 1'b0;
    chk("clr_fail_drop", health_fail, 1'b0);
    chk("clr_rosc_idle", rosc_en, 1'b0);
    t0 = cyc + 1;
    exp_q.push_back(32'hAAAA_AAAA);
    @(negedge clk);
    chk("clr_rosc_rise", rosc_en, 1'b1);
    wait_valid(144, "clr_rewarm");
    stop_idle("t4");

    // enable dropped mid-word: partial bits discarded, warmup reruns
    start(P_ALT);
    repeat (96) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_rosc_off", rosc_en, 1'b0);
    pat = P_CC;
    enable = 1'b1;
    t0 = cyc + 1;
    exp_q.push_back(32'hCCCC_CCCC);
    @(negedge clk);
    chk("drop_rosc_rise", rosc_en, 1'b1);
    wait_valid(144, "drop_rewarm");
    stop_idle("t6");
`endif

    chk("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
